// File: rtl/output_io.sv
// output_io: fabric-to-pad output cell for the AP3 I/O ring.
// Drives the pad data (OQZ) and pad drive-enable (OEZ) from fabric signals.
// The data path is either combinational or registered (MODE). A turnaround
// guard holds the pad released for TURN_CYCLES cycles after drive is withdrawn.
//
// Build option:
//   OUTPUT_IO_TURN_GUARD_EN  defined   -> HIZ/DRIVE/TURN FSM with turnaround counter
//                            undefined -> OEZ is IE registered, BUSY tied low
//
// Parameters:
//   MODE         "out_buff" (OQZ = F2A) or "out_reg" (OQZ = registered F2A)
//   TURN_CYCLES  forced hi-Z cycles after drive release, 0..15
// Ports:
//   IQC   in   clock, rising edge
//   QRT   in   asynchronous active-low reset
//   F2A   in   data from fabric
//   IE    in   fabric request to drive the pad
//   HOLD  in   data register freeze (out_reg only)
//   OQZ   out  data to pad buffer
//   OEZ   out  pad drive enable (1 = driving)
//   BUSY  out  turnaround in progress
module output_io #(
   parameter string       MODE        = "out_buff",
   parameter int unsigned TURN_CYCLES = 1
) (
   input  logic IQC,
   input  logic QRT,
   input  logic F2A,
   input  logic IE,
   input  logic HOLD,
   output logic OQZ,
   output logic OEZ,
   output logic BUSY
);

   localparam bit IS_REG = (MODE == "out_reg");

   // The turnaround counter is 4 bits wide; larger values cannot be honoured.
   if (TURN_CYCLES > 15) begin : g_turn_range
      $error("output_io: TURN_CYCLES must be in 0..15");
   end

   // Data register: loads F2A unless HOLD freezes it.
   logic data_q;
   logic data_d;

   always_comb begin
      data_d = data_q;
      if (!HOLD) begin
         data_d = F2A;
      end
   end

   always_ff @(posedge IQC or negedge QRT) begin
      if (!QRT) begin
         data_q <= 1'b0;
      end else begin
         data_q <= data_d;
      end
   end

   // In out_buff the pad follows F2A directly, including during reset.
   assign OQZ = IS_REG ? data_q : F2A;

   logic oez_q;
   logic oez_d;

`ifdef OUTPUT_IO_TURN_GUARD_EN
   localparam int unsigned CNT_W = 4;
   localparam bit TURN_EN = (TURN_CYCLES != 0);
   localparam logic [CNT_W-1:0] TURN_LOAD =
      TURN_EN ? CNT_W'(TURN_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      HIZ   = 2'd0,
      DRIVE = 2'd1,
      TURN  = 2'd2
   } state_e;

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             busy_q;
   logic             busy_d;

   // State register, counter and registered output decodes.
   always_ff @(posedge IQC or negedge QRT) begin
      if (!QRT) begin
         state_q <= HIZ;
         cnt_q   <= '0;
         oez_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         oez_q   <= oez_d;
         busy_q  <= busy_d;
      end
   end

   // Next state; IE is ignored in TURN so a request there is dropped, not queued.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         HIZ: begin
            if (IE) begin
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (!IE) begin
               if (TURN_EN) begin
                  state_d = TURN;
                  cnt_d   = TURN_LOAD;
               end else begin
                  state_d = HIZ;
               end
            end
         end
         TURN: begin
            if (cnt_q == '0) begin
               state_d = HIZ;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = HIZ;
            cnt_d   = '0;
         end
      endcase
      // Outputs decoded from the next state so they are flopped, not combinational.
      oez_d  = (state_d == DRIVE);
      busy_d = (state_d == TURN);
   end

   assign BUSY = busy_q;
`else
   // No guard: drive enable is simply IE delayed by one cycle.
   always_comb begin
      oez_d = IE;
   end

   always_ff @(posedge IQC or negedge QRT) begin
      if (!QRT) begin
         oez_q <= 1'b0;
      end else begin
         oez_q <= oez_d;
      end
   end

   assign BUSY = 1'b0;
`endif

   assign OEZ = oez_q;

endmodule
